// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, the NOP word shown
// while nothing has been fetched, and word alignment of fetch addresses.
package if_stage_pkg;

  typedef enum logic [1:0] {
    FS_BOOT = 2'd0,
    FS_REQ  = 2'd1,
    FS_WAIT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// Two-entry fetch output buffer: an output register that decode sees, plus
// one skid entry that absorbs a response arriving while decode is stalled.
module if_skid_buffer
  import if_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  logic        push_i,
  input  logic [31:0] push_instr_i,
  input  logic [31:0] push_pc_i,
  input  logic        stall_i,
  output logic        valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [1:0]  cnt_next_o
);

  logic        out_v_q, out_v_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        skid_v_q, skid_v_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        pop;

  always_comb begin
    out_v_d      = out_v_q;
    out_instr_d  = out_instr_q;
    out_pc_d     = out_pc_q;
    skid_v_d     = skid_v_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    pop          = out_v_q & ~stall_i;
    if (flush_i) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else if (skid_v_q) begin
      // The issue gate guarantees no push can arrive while both entries stay full.
      if (pop) begin
        out_v_d      = 1'b1;
        out_instr_d  = skid_instr_q;
        out_pc_d     = skid_pc_q;
        skid_v_d     = push_i;
        skid_instr_d = push_instr_i;
        skid_pc_d    = push_pc_i;
      end
    end else if (out_v_q && !pop) begin
      if (push_i) begin
        skid_v_d     = 1'b1;
        skid_instr_d = push_instr_i;
        skid_pc_d    = push_pc_i;
      end
    end else begin
      out_v_d = push_i;
      if (push_i) begin
        out_instr_d = push_instr_i;
        out_pc_d    = push_pc_i;
      end
    end
    cnt_next_o = {1'b0, out_v_d} + {1'b0, skid_v_d};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_v_q      <= 1'b0;
      out_instr_q  <= NOP_INSTR;
      out_pc_q     <= 32'h0;
      skid_v_q     <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= 32'h0;
    end else begin
      out_v_q      <= out_v_d;
      out_instr_q  <= out_instr_d;
      out_pc_q     <= out_pc_d;
      skid_v_q     <= skid_v_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign valid_o = out_v_q;
  assign instr_o = out_instr_q;
  assign pc_o    = out_pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request at a time, branch/jump
// redirects that squash stale responses, and a 2-entry buffer toward decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         stall_i,
  input  logic         branch_taken_i,
  input  logic [31:0]  branch_target_i,
  input  logic         jump_i,
  input  logic [31:0]  jump_target_i,
  output logic         imem_req_o,
  output logic [31:0]  imem_addr_o,
  input  logic         imem_gnt_i,
  input  logic         imem_rvalid_i,
  input  logic [31:0]  imem_rdata_i,
  output logic         if_valid_o,
  output logic [31:0]  if_instr_o,
  output logic [31:0]  if_pc_o,
  output fetch_state_e dbg_state_o
);

  fetch_state_e state_q, state_d;
  logic         req_q, req_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  logic         outst_q, outst_d;
  logic         discard_q, discard_d;
  logic         redirect;
  logic [31:0]  redirect_tgt;
  logic         push;
  logic [1:0]   buf_cnt_next;

  // The EX branch belongs to an older instruction than the ID jump, so it wins.
  always_comb begin
    redirect     = branch_taken_i | jump_i;
    redirect_tgt = word_align(branch_taken_i ? branch_target_i : jump_target_i);
    push         = imem_rvalid_i & outst_q & ~discard_q & ~redirect;
  end

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    pend_pc_d = pend_pc_q;
    outst_d   = outst_q;
    discard_d = discard_q;
    case (state_q)
      FS_BOOT: begin
        state_d = FS_REQ;
        req_d   = 1'b1;
        if (redirect) addr_d = redirect_tgt;
      end
      FS_REQ: begin
        if (imem_gnt_i) begin
          state_d   = FS_WAIT;
          req_d     = 1'b0;
          outst_d   = 1'b1;
          pend_pc_d = addr_q;
          if (redirect) begin
            discard_d = 1'b1;
            addr_d    = redirect_tgt;
          end else begin
            addr_d = addr_q + 32'd4;
          end
        end else if (redirect) begin
          addr_d = redirect_tgt;
        end
      end
      FS_WAIT: begin
        if (outst_q && imem_rvalid_i) begin
          outst_d   = 1'b0;
          discard_d = 1'b0;
          if (redirect) addr_d = redirect_tgt;
          if (buf_cnt_next < 2'd2) begin
            state_d = FS_REQ;
            req_d   = 1'b1;
          end
        end else if (outst_q) begin
          if (redirect) begin
            discard_d = 1'b1;
            addr_d    = redirect_tgt;
          end
        end else begin
          // Response already in; idle here until decode frees a buffer entry.
          if (redirect) addr_d = redirect_tgt;
          if (buf_cnt_next < 2'd2) begin
            state_d = FS_REQ;
            req_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = FS_BOOT;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= FS_BOOT;
      req_q     <= 1'b0;
      addr_q    <= word_align(RESET_PC);
      pend_pc_q <= 32'h0;
      outst_q   <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      pend_pc_q <= pend_pc_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
    end
  end

  if_skid_buffer u_skid (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (redirect),
    .push_i       (push),
    .push_instr_i (imem_rdata_i),
    .push_pc_i    (pend_pc_q),
    .stall_i      (stall_i),
    .valid_o      (if_valid_o),
    .instr_o      (if_instr_o),
    .pc_o         (if_pc_o),
    .cnt_next_o   (buf_cnt_next)
  );

  assign imem_req_o  = req_q;
  assign imem_addr_o = addr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: an instruction memory model with variable grant and
// response latency, a decode side with stalls, and an in-order scoreboard.
module tb_if_stage;
  import if_stage_pkg::*;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  // Handshake: a request is accepted in the cycle imem_req_o and imem_gnt_i
  // are both high; its data returns with imem_rvalid_i in a later cycle and is
  // never back-pressured; decode takes if_* in any cycle if_valid_o is high
  // and stall_i is low.

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;

  logic         stall_i = 1'b0;
  logic         branch_taken_i = 1'b0;
  logic [31:0]  branch_target_i = 32'h0;
  logic         jump_i = 1'b0;
  logic [31:0]  jump_target_i = 32'h0;
  logic         imem_req_o;
  logic [31:0]  imem_addr_o;
  logic         imem_gnt_i = 1'b0;
  logic         imem_rvalid_i = 1'b0;
  logic [31:0]  imem_rdata_i = 32'h0;
  logic         if_valid_o;
  logic [31:0]  if_instr_o;
  logic [31:0]  if_pc_o;
  fetch_state_e dbg_state;

  if_stage #(.RESET_PC(TB_RESET_PC)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .if_valid_o      (if_valid_o),
    .if_instr_o      (if_instr_o),
    .if_pc_o         (if_pc_o),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];
  logic [31:0] exp_addr = TB_RESET_PC;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] last_gnt_addr = 32'h0;
  logic        pend_v = 1'b0;
  logic        pend_drop = 1'b0;
  logic        got_gnt = 1'b0;
  int          pend_cnt = 0;
  int          gnt_mode = 1;   // 0 random, 1 always, 2 never
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          stall_mode = 0; // 0 off, 1 on, 2 random
  int          redir_pct = 0;
  logic        late_rv = 1'b0;
  logic        br_req = 1'b0;
  logic        jmp_req = 1'b0;
  logic [31:0] br_tgt = 32'h0;
  logic [31:0] jmp_tgt = 32'h0;
  logic        hold_chk = 1'b0;
  logic        prv_v = 1'b0;
  logic [31:0] prv_i = 32'h0;
  logic [31:0] prv_pc = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    logic        redir;
    logic [31:0] tgt;
    logic [63:0] e;
    logic [31:0] w;
    @(negedge clk);
    got_gnt = 1'b0;
    if (hold_chk) begin
      check("hold_valid", 32'(if_valid_o), 32'(prv_v));
      check("hold_instr", if_instr_o, prv_i);
      check("hold_pc", if_pc_o, prv_pc);
    end
    if (imem_req_o) check("one_outstanding", 32'(pend_v), 32'd0);
    check("addr_align", 32'(imem_addr_o[1:0]), 32'd0);

    case (stall_mode)
      0:       stall_i = 1'b0;
      1:       stall_i = 1'b1;
      default: stall_i = ($urandom_range(99) < 40);
    endcase
    branch_taken_i  = br_req;
    branch_target_i = br_tgt;
    jump_i          = jmp_req;
    jump_target_i   = jmp_tgt;
    if (!br_req && !jmp_req && redir_pct > 0 && $urandom_range(99) < 32'(redir_pct)) begin
      branch_taken_i  = 1'($urandom_range(1));
      jump_i          = 1'($urandom_range(1));
      if (!branch_taken_i) jump_i = 1'b1;
      branch_target_i = $urandom;
      jump_target_i   = $urandom;
    end
    br_req  = 1'b0;
    jmp_req = 1'b0;
    redir   = branch_taken_i | jump_i;
    tgt     = branch_taken_i ? branch_target_i : jump_target_i;
    tgt     = tgt & 32'hFFFF_FFFC;

    if (if_valid_o && !stall_i) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_valid", 32'(if_valid_o), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", if_pc_o, e[63:32]);
        check("sb_instr", if_instr_o, e[31:0]);
      end
    end

    imem_rvalid_i = 1'b0;
    imem_rdata_i  = $urandom;
    if (pend_v) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        w             = mem_word(pend_addr);
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = w;
        pend_v        = 1'b0;
        if (!pend_drop && !redir) exp_q.push_back({pend_addr, w});
      end else if (redir) begin
        pend_drop = 1'b1;
      end
    end else if (late_rv) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hBAD0_0002;
    end

    imem_gnt_i = 1'b0;
    if (imem_req_o && (gnt_mode == 1 || (gnt_mode == 0 && $urandom_range(99) < 60))) begin
      imem_gnt_i    = 1'b1;
      got_gnt       = 1'b1;
      last_gnt_addr = imem_addr_o;
      check("req_addr", imem_addr_o, exp_addr);
      pend_v    = 1'b1;
      pend_cnt  = int'($urandom_range(lat_hi, lat_lo));
      pend_addr = exp_addr;
      pend_drop = redir;
      exp_addr  = exp_addr + 32'd4;
    end
    if (redir) begin
      exp_q.delete();
      exp_addr = tgt;
    end
    hold_chk = stall_i && !redir && if_valid_o;
    prv_v    = if_valid_o;
    prv_i    = if_instr_o;
    prv_pc   = if_pc_o;
  endtask

  task automatic run_until_grant(input int budget);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!got_gnt && n < budget);
    if (!got_gnt) check("grant_timeout", 32'(got_gnt), 32'd1);
  endtask

  task automatic do_reset(input logic late_rvalid);
    @(negedge clk);
    rst_ni         = 1'b0;
    stall_i        = 1'b0;
    branch_taken_i = 1'b0;
    jump_i         = 1'b0;
    imem_gnt_i     = 1'b0;
    imem_rvalid_i  = 1'b0;
    exp_q.delete();
    pend_v   = 1'b0;
    hold_chk = 1'b0;
    exp_addr = TB_RESET_PC;
    #1;
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_addr", imem_addr_o, TB_RESET_PC);
    check("rst_valid", 32'(if_valid_o), 32'd0);
    check("rst_instr", if_instr_o, 32'h0000_0013);
    check("rst_pc", if_pc_o, 32'h0);
    check("rst_state", 32'(dbg_state), 32'(FS_BOOT));
    repeat (2) @(negedge clk);
    rst_ni = 1'b1;
    if (late_rvalid) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hBAD0_0001;
    end
    #1;
    check("boot_req_low", 32'(imem_req_o), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset(1'b0);

    // First fetch after reset: addr 0, data back one cycle after grant.
    step();
    step();
    step();
    check("first_valid", 32'(if_valid_o), 32'd1);
    check("first_pc", if_pc_o, TB_RESET_PC);
    check("first_instr", if_instr_o, mem_word(TB_RESET_PC));
    check("second_req", 32'(imem_req_o), 32'd1);
    check("second_addr", imem_addr_o, TB_RESET_PC + 32'd4);

    // Branch while a response is outstanding: stale data dropped.
    lat_lo = 4;
    lat_hi = 4;
    run_until_grant(20);
    step();
    br_req = 1'b1;
    br_tgt = 32'h0000_0103;
    step();
    lat_lo = 1;
    lat_hi = 1;
    step();
    check("flush_valid", 32'(if_valid_o), 32'd0);
    run_until_grant(20);
    check("branch_req_addr", last_gnt_addr, 32'h0000_0100);
    repeat (4) step();

    // Branch and jump together: branch target wins.
    br_req  = 1'b1;
    br_tgt  = 32'h0000_0200;
    jmp_req = 1'b1;
    jmp_tgt = 32'h0000_0300;
    step();
    run_until_grant(20);
    check("prio_req_addr", last_gnt_addr, 32'h0000_0200);
    repeat (4) step();

    // Five stalled cycles with responses still arriving.
    stall_mode = 1;
    repeat (5) step();
    check("stall_valid", 32'(if_valid_o), 32'd1);
    stall_mode = 0;
    repeat (8) step();

    // Address wrap at the top of the space.
    jmp_req = 1'b1;
    jmp_tgt = 32'hFFFF_FFFC;
    step();
    run_until_grant(20);
    check("wrap_first", last_gnt_addr, 32'hFFFF_FFFC);
    run_until_grant(20);
    check("wrap_next", last_gnt_addr, 32'h0000_0000);
    repeat (4) step();

    // Reset while waiting for data; late responses must be ignored.
    lat_lo = 6;
    lat_hi = 6;
    run_until_grant(20);
    step();
    do_reset(1'b1);
    lat_lo   = 1;
    lat_hi   = 1;
    late_rv  = 1'b1;
    gnt_mode = 2;
    step();
    late_rv  = 1'b0;
    gnt_mode = 1;
    run_until_grant(20);
    check("restart_addr", last_gnt_addr, TB_RESET_PC);
    repeat (3) step();
    check("restart_pc", if_pc_o, TB_RESET_PC);

    // Random traffic.
    gnt_mode   = 0;
    lat_lo     = 1;
    lat_hi     = 3;
    stall_mode = 2;
    redir_pct  = 5;
    repeat (3000) step();

    // Drain everything still in flight.
    redir_pct  = 0;
    stall_mode = 0;
    gnt_mode   = 2;
    repeat (10) step();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address of the first request after reset.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous and active-low.
REQ-004 stall_i  in  1  decode not accepting; hold if_* outputs.
REQ-005 branch_taken_i  in  1  EX-stage branch resolved taken (from branch condition logic).
REQ-006 branch_target_i  in  32  EX-stage branch target.
REQ-007 jump_i  in  1  ID-stage JAL/JALR redirect.
REQ-008 jump_target_i  in  32  ID-stage jump target.
REQ-009 imem_req_o  out  1  instruction memory request.
REQ-010 imem_addr_o  out  32  request address; bits [1:0] always 0.
REQ-011 imem_gnt_i  in  1  request accepted this cycle.
REQ-012 imem_rvalid_i  in  1  read data valid; cannot be back-pressured.
REQ-013 imem_rdata_i  in  32  fetched instruction word.
REQ-014 if_valid_o  out  1  if_instr_o/if_pc_o hold a live instruction.
REQ-015 if_instr_o  out  32  instruction to decode.
REQ-016 if_pc_o  out  32  PC of if_instr_o.

Function
REQ-017 Redirect = branch_taken_i | jump_i; branch_taken_i SHALL win when both are high (older instruction).
REQ-018 Redirect target bits [1:0] SHALL be forced to 0.
REQ-019 At most one request SHALL be outstanding (granted, no rvalid yet).
REQ-020 FSM states: BOOT (first cycle after reset release, req low), REQ (req high, waiting gnt), WAIT (granted, waiting rvalid).
REQ-021 BOOT -> REQ unconditionally; REQ -> WAIT on gnt; WAIT -> REQ on rvalid when buffer has a free slot next cycle, else WAIT-IDLE held in WAIT with req low until a slot frees.
REQ-022 Request address SHALL advance by 4 (mod 2^32, wrap 0xFFFF_FFFC -> 0) on each grant.
REQ-023 While in REQ with gnt low, a redirect SHALL replace imem_addr_o with the target from the next cycle; address otherwise stable until gnt.
REQ-024 Redirect in WAIT SHALL set a discard flag; the pending rvalid SHALL be dropped, then the next request goes to the target.
REQ-025 Redirect coincident with rvalid SHALL drop that response.
REQ-026 Output buffer: 2 entries (output register + skid); rvalid with output occupied and stall_i high SHALL fill skid.
REQ-027 New request SHALL be issued only if at least one buffer entry will be free when its data returns.
REQ-028 Any redirect SHALL clear both buffer entries; if_valid_o low the following cycle; redirect overrides stall_i.
REQ-029 With stall_i high and no redirect, if_valid_o/if_instr_o/if_pc_o SHALL be held unchanged.
REQ-030 Fetch latency: rvalid in cycle N with empty buffer and no stall -> if_valid_o high in cycle N+1.
REQ-031 Minimum redirect-to-request: redirect in cycle N -> imem_req_o with target addr in cycle N+1 (if no response outstanding).

Reset
REQ-032 On rst_ni low: state BOOT, imem_req_o=0, imem_addr_o=RESET_PC, if_valid_o=0, if_instr_o=32'h0000_0013 (NOP), if_pc_o=0, discard=0, buffer empty.
REQ-033 Reset mid-transaction SHALL abandon the outstanding request; any later rvalid before first new grant SHALL be ignored.

Structure
REQ-034 FSM state enum and NOP constant SHALL live in the shared core package; instruction-format macros stay in the existing format header.
REQ-035 The 2-entry buffer SHALL be a sub-module named if_skid_buffer.

Verification
REQ-036 Reset release, gnt=1, rvalid 1 cycle later -> first req addr 0x0, if_pc_o=0x0 valid, next req 0x4.
REQ-037 branch_taken_i=1, target 0x103 while in WAIT -> pending rvalid dropped, next req addr 0x100, no instr from old path visible.
REQ-038 branch_taken_i and jump_i same cycle, targets 0x200/0x300 -> req addr 0x200.
REQ-039 stall_i held 5 cycles with two responses arriving -> both instructions emerge in order, none lost, if_* stable during stall.
REQ-040 PC at 0xFFFF_FFFC granted -> next req addr 0x0000_0000.
REQ-041 rst_ni low during WAIT, late rvalid after release -> ignored, fetch restarts at RESET_PC.
